// File: rtl/sub_pkg.sv
// Shared encodings for the nibble-serial subtract sequencer.
package sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int NIB_BITS = 4;

endpackage

// File: rtl/fullSub4.sv
// 4-bit ripple-borrow subtractor: diff = a - b - bin, purely combinational.
module fullSub4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       bin,
    output logic [3:0] diff,
    output logic       bout
);

    logic [4:0] brw;

    always_comb begin
        brw     = '0;
        diff    = '0;
        brw[0]  = bin;
        for (int i = 0; i < 4; i++) begin
            diff[i]  = a[i] ^ b[i] ^ brw[i];
            brw[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & brw[i]);
        end
        bout = brw[4];
    end

endmodule

// File: rtl/sub4_serial_ctrl.sv
// Sequences a WIDTH-bit a - b - bin through one shared 4-bit subtractor,
// LSB nibble first, with valid/ready handshakes on operands and result.
//
// state   | meaning
// IDLE    | in_ready=1, waiting for operands
// RUN     | one nibble per clock through u_sub, borrow chained in borrow_q
// DONE    | out_valid=1, result held until out_ready
module sub4_serial_ctrl
    import sub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             ovf
);

    localparam int NIB   = WIDTH / NIB_BITS;
    localparam int CNT_W = $clog2(NIB);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NIB - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   a_q, b_q, diff_q, diff_next;
    logic               borrow_q, bout_q, zero_q, ovf_q;
    logic [NIB_BITS-1:0] a_nib, b_nib, dp_diff;
    logic               dp_bout;
    logic               last_nib;

    assign last_nib = (cnt_q == LAST);

    always_comb begin
        a_nib     = '0;
        b_nib     = '0;
        diff_next = diff_q;
        for (int i = 0; i < NIB; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                a_nib                          = a_q[NIB_BITS*i +: NIB_BITS];
                b_nib                          = b_q[NIB_BITS*i +: NIB_BITS];
                diff_next[NIB_BITS*i +: NIB_BITS] = dp_diff;
            end
        end
    end

    fullSub4 u_sub (
        .a    (a_nib),
        .b    (b_nib),
        .bin  (borrow_q),
        .diff (dp_diff),
        .bout (dp_bout)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid)  state_d = ST_RUN;
            ST_RUN:  if (last_nib)  state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        borrow_q <= bin;
                        cnt_q    <= '0;
                        diff_q   <= '0;
                    end
                end
                ST_RUN: begin
                    diff_q   <= diff_next;
                    borrow_q <= dp_bout;
                    // Exit wins over increment so cnt never wraps.
                    if (last_nib) begin
                        bout_q <= dp_bout;
                        zero_q <= (diff_next == '0);
                        ovf_q  <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) &
                                  (a_q[WIDTH-1] ^ diff_next[WIDTH-1]);
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_sub4_serial_ctrl.sv
// Randomized self-checking bench for sub4_serial_ctrl against an arithmetic model.
module tb_sub4_serial_ctrl;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a, b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout, zero, ovf;

    int checks   = 0;
    int failures = 0;

    sub4_serial_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .zero      (zero),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: plain integer arithmetic on the operands.
    task automatic model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb, input logic mbin,
                         output logic [WIDTH-1:0] ed, output logic eb, output logic ez, output logic eo);
        longint ua, ub, sa, sb, r;
        ua = longint'(ma);
        ub = longint'(mb);
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        r  = ua - ub - longint'(mbin);
        ed = WIDTH'(r);
        eb = (ua < ub + longint'(mbin));
        ez = (ed == '0);
        r  = sa - sb - longint'(mbin);
        eo = (r < -(longint'(1) << (WIDTH-1))) || (r > (longint'(1) << (WIDTH-1)) - 1);
    endtask

    // Accept an operation and wait for out_valid; leaves the DUT in DONE.
    task automatic start_and_wait(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                                  input logic tbin, input string tag);
        int lat;
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            step();
            guard++;
        end
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        a = ta; b = tb_; bin = tbin; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        a = WIDTH'($urandom); b = WIDTH'($urandom); bin = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 40) begin
            chk({tag, "_run_in_ready"}, 32'(in_ready), 32'd0);
            step();
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(NIB));
    endtask

    task automatic check_result(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                                input logic tbin, input string tag);
        logic [WIDTH-1:0] ed;
        logic eb, ez, eo;
        model(ta, tb_, tbin, ed, eb, ez, eo);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_diff"}, 32'(diff), 32'(ed));
        chk({tag, "_bout"}, 32'(bout), 32'(eb));
        chk({tag, "_zero"}, 32'(zero), 32'(ez));
        chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_rel_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_rel_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                          input logic tbin, input string tag);
        start_and_wait(ta, tb_, tbin, tag);
        check_result(ta, tb_, tbin, tag);
        release_result(tag);
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb, held_diff;
        logic rbin, held_bout, held_zero, held_ovf;
        int wait_cyc;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; bin = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_flags", {29'd0, bout, zero, ovf}, 32'd0);

        // Directed cases, including fixed expected values.
        run_op(16'h1234, 16'h0234, 1'b0, "t1");
        start_and_wait(16'h0000, 16'h0001, 1'b0, "t2");
        chk("t2_diff_const", 32'(diff), 32'h0000_FFFF);
        chk("t2_bout_const", 32'(bout), 32'd1);
        release_result("t2");
        start_and_wait(16'h8000, 16'h0001, 1'b0, "t3a");
        chk("t3a_const", {diff, 13'd0, bout, zero, ovf}, {16'h7FFF, 16'h0001});
        release_result("t3a");
        start_and_wait(16'h7FFF, 16'hFFFF, 1'b0, "t3b");
        chk("t3b_const", {diff, 13'd0, bout, zero, ovf}, {16'h8000, 16'h0005});
        release_result("t3b");
        start_and_wait(16'hABCD, 16'hABCD, 1'b0, "t4a");
        chk("t4a_const", {diff, 13'd0, bout, zero, ovf}, {16'h0000, 16'h0002});
        release_result("t4a");
        start_and_wait(16'hABCD, 16'hABCD, 1'b1, "t4b");
        chk("t4b_const", {diff, 13'd0, bout, zero, ovf}, {16'hFFFF, 16'h0004});
        release_result("t4b");

        // Back-pressure: result held, new operands ignored.
        start_and_wait(16'h5555, 16'h1111, 1'b1, "t5");
        check_result(16'h5555, 16'h1111, 1'b1, "t5");
        held_diff = diff; held_bout = bout; held_zero = zero; held_ovf = ovf;
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            a = 16'h0F0F; b = 16'hF0F0; bin = 1'b0;
            step();
            chk("t5_hold_valid", 32'(out_valid), 32'd1);
            chk("t5_hold_in_ready", 32'(in_ready), 32'd0);
            chk("t5_hold_out", {diff, 13'd0, bout, zero, ovf},
                {held_diff, 13'd0, held_bout, held_zero, held_ovf});
        end
        in_valid = 1'b0;
        release_result("t5");
        chk("t5_idle_diff", 32'(diff), 32'(held_diff));

        // Reset in the middle of RUN (cnt==2).
        a = 16'hFFFF; b = 16'h0001; bin = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_out_valid", 32'(out_valid), 32'd0);
        chk("t6_diff", 32'(diff), 32'd0);
        chk("t6_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < NIB + 2; i++) begin
            step();
            chk("t6_no_valid", 32'(out_valid), 32'd0);
        end
        run_op(16'h1234, 16'h0234, 1'b0, "t6_t1");

        // Randomized operations with random back-pressure and idle gaps.
        for (int n = 0; n < 40; n++) begin
            ra = WIDTH'($urandom);
            rb = (n % 5 == 0) ? ra : WIDTH'($urandom);
            rbin = 1'($urandom);
            start_and_wait(ra, rb, rbin, "rnd");
            check_result(ra, rb, rbin, "rnd");
            wait_cyc = $urandom_range(0, 3);
            for (int w = 0; w < wait_cyc; w++) begin
                step();
                chk("rnd_wait_valid", 32'(out_valid), 32'd1);
            end
            release_result("rnd");
            wait_cyc = $urandom_range(0, 2);
            for (int w = 0; w < wait_cyc; w++) step();
        end

        // out_ready held high permanently: one-cycle out_valid pulse.
        out_ready = 1'b1;
        ra = WIDTH'($urandom); rb = WIDTH'($urandom);
        start_and_wait(ra, rb, 1'b0, "perm");
        check_result(ra, rb, 1'b0, "perm");
        step();
        chk("perm_drop", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
